mux2_sel_reg: RTL and testbench
===============================

Name: mux2_sel_reg

Overview:
- Parameterised 2:1 word multiplexer with a registered output stage and valid tracking.
- Used in the arithmetic unit for operand/carry-in steering: sel=0 passes the true operand (add), sel=1 passes the inverted operand (subtract).
- The carry-in instance uses constants in0=0, in1=1, so carry-in equals sel.
- Provides a zero-latency combinational output (drop-in for the primitive) and a one-cycle registered output.

Parameters:
- WIDTH, 1, data width in bits of in0, in1, dout_comb, dout; legal range 1..64.
- RESET_VAL, 0 (all zeros), value loaded into dout on reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  data selected when sel=0.
- in1  input  WIDTH  data selected when sel=1.
- sel  input  1  select (AddSub in the arithmetic unit).
- in_valid  input  1  qualifies in0/in1/sel for capture.
- hold  input  1  freezes the registered stage when high.
- dout_comb  output  WIDTH  combinational result: sel ? in1 : in0.
- dout  output  WIDTH  registered result.
- out_valid  output  1  high when dout holds a word captured on the previous edge.
- sel_q  output  1  registered copy of sel captured together with dout.

Behaviour:
- Combinational path:
  - dout_comb = in1 when sel=1, and in0 when sel=0, bitwise for every bit.
  - No clock dependency and no reset dependency.
  - If sel is X/Z, dout_comb bits are X except where in0 and in1 agree; those bits take the common value.
- Reset, asserted asynchronously when rst_n falls, regardless of clk:
  - dout=RESET_VAL, sel_q=0, out_valid=0.
  - Outputs stay held while rst_n=0.
  - The first capture can occur on the first rising clk edge after rst_n rises.
- Rising edge with rst_n=1, evaluated in this priority order:
  - hold=1: dout, sel_q and out_valid keep their values, whatever in_valid is. A hold does not consume input.
  - hold=0 and in_valid=1: dout <= (sel ? in1 : in0), sel_q <= sel, out_valid <= 1.
  - hold=0 and in_valid=0: dout and sel_q keep their values; out_valid <= 0.
- Latency:
  - dout_comb: 0 cycles.
  - dout/out_valid: 1 cycle after the capturing edge.
  - Throughput: one word per cycle.
- Back-to-back in_valid=1 updates dout every cycle with no bubble.
- sel changing in the same cycle as capture: the value sampled at the edge is used.
- Reset asserted mid-stream discards the pending word; out_valid drops immediately, not at the next edge.
- No arithmetic and no width conversion: inputs, dout_comb and dout are all exactly WIDTH bits.

Test Plan:
- Reset: hold rst_n=0 with clk toggling and inputs random -> dout=RESET_VAL, out_valid=0, sel_q=0. Pulse rst_n low between edges while out_valid=1 -> out_valid falls without waiting for a clk edge.
- Add/sub operand steering, WIDTH=1, sweep in0=B in {0,1}, in1=~B, sel in {0,1}:
  - dout_comb equals B when sel=0 and ~B when sel=1.
  - With in_valid=1 and hold=0, dout equals the same value one edge later and out_valid=1.
- Carry-in constant, WIDTH=1, in0=0, in1=1:
  - sel=0 -> dout_comb=0; sel=1 -> dout_comb=1.
  - Registered: sel_q=sel and dout=sel after the edge.
- Streaming, WIDTH=4: in0=0x3, in1=0xC with sel pattern 0,1,1,0 on consecutive cycles and in_valid=1 -> dout sequence 0x3, 0xC, 0xC, 0x3, each one cycle late, out_valid continuously 1.
- Hold and gaps, WIDTH=4:
  - dout=0xA, then hold=1 for 3 cycles while inputs change -> dout stays 0xA and out_valid is unchanged.
  - Then hold=0, in_valid=0 -> out_valid=0 and dout stays 0xA.
- Exhaustive combinational check, WIDTH=4: all 512 combinations of in0, in1 and sel -> dout_comb matches (sel ? in1 : in0) for every combination.

Source files
------------

// File: rtl/mux2_sel_reg_if.sv
// Bus bundle for the 2:1 select mux. The master drives the operands and
// controls, and the slave (the mux) returns the combinational and registered results.
interface mux2_sel_reg_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             sel;
    logic             in_valid;
    logic             hold;
    logic [WIDTH-1:0] dout_comb;
    logic [WIDTH-1:0] dout;
    logic             out_valid;
    logic             sel_q;

    modport master (
        output in0, in1, sel, in_valid, hold,
        input  dout_comb, dout, out_valid, sel_q
    );

    modport slave (
        input  in0, in1, sel, in_valid, hold,
        output dout_comb, dout, out_valid, sel_q
    );
endinterface

// File: rtl/mux2_sel_reg.sv
// 2:1 word mux with a zero-latency path and a one-cycle registered stage.
// It steers operands and carry-in for add/subtract (sel=1 selects in1).
module mux2_sel_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic           clk,
    input  logic           rst_n,
    mux2_sel_reg_if.slave  bus
);

    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_dout;
    logic             r_sel_q;
    logic             r_out_valid;

    // The conditional operator is kept on purpose. When sel is X it merges in0/in1,
    // so bits where the two inputs agree stay known.
    assign w_mux = bus.sel ? bus.in1 : bus.in0;

    assign bus.dout_comb = w_mux;
    assign bus.dout      = r_dout;
    assign bus.sel_q     = r_sel_q;
    assign bus.out_valid = r_out_valid;

    // Capture stage: hold freezes everything, and a gap only clears the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= RESET_VAL;
            r_sel_q     <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!bus.hold) begin
            if (bus.in_valid) begin
                r_dout      <= w_mux;
                r_sel_q     <= bus.sel;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux2_sel_reg.sv
// Scoreboard bench for mux2_sel_reg. It runs a WIDTH=4 instance and a WIDTH=1 instance in lockstep.
module tb_mux2_sel_reg;

    localparam logic [3:0] RV4 = 4'h5;
    localparam logic       RV1 = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mux2_sel_reg_if #(.WIDTH(4)) if4 ();
    mux2_sel_reg_if #(.WIDTH(1)) if1 ();

    mux2_sel_reg #(.WIDTH(4), .RESET_VAL(RV4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    mux2_sel_reg #(.WIDTH(1), .RESET_VAL(RV1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected post-edge state {out_valid, sel_q, dout}, one entry per clocked cycle.
    logic [5:0] q4[$];
    logic [2:0] q1[$];
    logic [5:0] e4;
    logic [2:0] e1;

    // Reference state: what the registered stage should hold
    logic [3:0] m4_dout;
    logic       m4_v, m4_s;
    logic       m1_dout, m1_v, m1_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m4_dout = RV4; m4_v = 1'b0; m4_s = 1'b0;
        m1_dout = RV1; m1_v = 1'b0; m1_s = 1'b0;
    endtask

    // One clock of stimulus on both instances. It checks the comb outputs and queues the registered expectation.
    task automatic step(input logic [3:0] a4, input logic [3:0] b4, input logic s4,
                        input logic v4, input logic h4,
                        input logic a1, input logic b1, input logic s1,
                        input logic v1, input logic h1);
        logic [3:0] x4;
        logic       x1;
        @(negedge clk);
        #1;
        if4.in0 = a4; if4.in1 = b4; if4.sel = s4; if4.in_valid = v4; if4.hold = h4;
        if1.in0 = a1; if1.in1 = b1; if1.sel = s1; if1.in_valid = v1; if1.hold = h1;
        #1;
        for (int i = 0; i < 4; i++) x4[i] = s4 ? b4[i] : a4[i];
        x1 = s1 ? b1 : a1;
        check("comb4", 64'(if4.dout_comb), 64'(x4));
        check("comb1", 64'(if1.dout_comb), 64'(x1));
        if (!h4) begin
            if (v4) begin m4_dout = x4; m4_s = s4; m4_v = 1'b1; end
            else    m4_v = 1'b0;
        end
        if (!h1) begin
            if (v1) begin m1_dout = x1; m1_s = s1; m1_v = 1'b1; end
            else    m1_v = 1'b0;
        end
        q4.push_back({m4_v, m4_s, m4_dout});
        q1.push_back({m1_v, m1_s, m1_dout});
    endtask

    task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic v, input logic h);
        step(a, b, s, v, h, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step1(input logic a, input logic b, input logic s,
                         input logic v, input logic h);
        step(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, a, b, s, v, h);
    endtask

    task automatic step_rand();
        step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout4"},  64'(if4.dout),      64'(RV4));
        check({tag, "_valid4"}, 64'(if4.out_valid), 64'(1'b0));
        check({tag, "_selq4"},  64'(if4.sel_q),     64'(1'b0));
        check({tag, "_dout1"},  64'(if1.dout),      64'(RV1));
        check({tag, "_valid1"}, 64'(if1.out_valid), 64'(1'b0));
        check({tag, "_selq1"},  64'(if1.sel_q),     64'(1'b0));
    endtask

    // Monitor: every negedge that has a pending expectation compares the registered outputs.
    always @(negedge clk) begin
        if (q4.size() > 0) begin
            e4 = q4.pop_front();
            check("reg4", 64'({if4.out_valid, if4.sel_q, if4.dout}), 64'(e4));
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check("reg1", 64'({if1.out_valid, if1.sel_q, if1.dout}), 64'(e1));
        end
    end

    initial begin
        if4.in0 = 4'h0; if4.in1 = 4'h0; if4.sel = 1'b0; if4.in_valid = 1'b1; if4.hold = 1'b0;
        if1.in0 = 1'b0; if1.in1 = 1'b0; if1.sel = 1'b0; if1.in_valid = 1'b1; if1.hold = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;

        // Reset held across clock edges with random inputs and in_valid high
        repeat (3) begin
            @(negedge clk);
            #1;
            if4.in0 = 4'($urandom_range(0, 15)); if4.in1 = 4'($urandom_range(0, 15));
            if4.sel = 1'($urandom_range(0, 1));
            if1.in0 = 1'($urandom_range(0, 1));  if1.in1 = 1'($urandom_range(0, 1));
            if1.sel = 1'($urandom_range(0, 1));
            #1;
            check_reset_outputs("rst_hold");
        end
        @(negedge clk);
        #1;
        if4.in_valid = 1'b0; if1.in_valid = 1'b0;
        rst_n = 1'b1;

        // Add/sub operand steering, WIDTH=1
        for (int bb = 0; bb < 2; bb++)
            for (int ss = 0; ss < 2; ss++)
                step1(1'(bb), ~1'(bb), 1'(ss), 1'b1, 1'b0);

        // Carry-in constants
        step1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Streaming, WIDTH=4
        step4(4'h3, 4'hC, 1'b0, 1'b1, 1'b0);
        step4(4'h3, 4'hC, 1'b1, 1'b1, 1'b0);
        step4(4'h3, 4'hC, 1'b1, 1'b1, 1'b0);
        step4(4'h3, 4'hC, 1'b0, 1'b1, 1'b0);

        // Hold for 3 cycles while inputs change, then a gap
        step4(4'hA, 4'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) step4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        step4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Mid-stream reset pulse between clock edges
        step(4'h9, 4'h6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        check("pre_pulse_valid4", 64'(if4.out_valid), 64'(m4_v));
        check("pre_pulse_valid1", 64'(if1.out_valid), 64'(m1_v));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_pulse");
        if4.in_valid = 1'b0; if4.hold = 1'b0;
        if1.in_valid = 1'b0; if1.hold = 1'b0;
        rst_n = 1'b1;
        model_reset();

        // Exhaustive comb sweep on WIDTH=4 with random registered-side controls
        for (int k = 0; k < 512; k++)
            step(4'(k), 4'(k >> 4), 1'(k >> 8),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));

        repeat (300) step_rand();

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(q4.size() + q1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
